// File: rtl/nibble_burst_accumulator.sv
// Operand stage for an external 4-bit adder: sums BURST_LEN samples and offers the total on valid/ready.
// Defining ACC_OVF_DETECT_EN adds a sticky per-burst wrap flag on ovf; otherwise ovf is tied low.
module nibble_burst_accumulator #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_z,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       ovf
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       drain;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign add_a   = acc_q;
  assign add_b   = in_data;
  assign out_sum = acc_q;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (accept) begin
      acc_d = add_z;
      if (cnt_q == LAST_CNT) begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (drain) begin
      // The next burst restarts from zero; the drain cycle itself takes no sample.
      acc_d   = '0;
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all state registers update together at the edge.
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ACC_OVF_DETECT_EN
  logic ovf_q, ovf_d;

  // A 4-bit unsigned add wrapped exactly when the result is smaller than the old sum.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = ovf_q | (add_z < acc_q);
    end else if (drain) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_burst_accumulator.sv
// Bench for nibble_burst_accumulator: directed scenarios plus random bursts against a sum-of-samples model.
// Expected ovf follows ACC_OVF_DETECT_EN, the same macro the design uses.
module tb_nibble_burst_accumulator;

  localparam int unsigned BL = 4;
`ifdef ACC_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, ovf;
  logic [3:0] in_data, add_a, add_b, add_z, out_sum;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
  logic [3:0] in_data1, add_a1, add_b1, add_z1, out_sum1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned model_tot = 0;
  int unsigned model_n   = 0;

  always #5 clk = ~clk;

  // External 4-bit ripple adders: z = (a + b) mod 16.
  assign add_z  = add_a + add_b;
  assign add_z1 = add_a1 + add_b1;

  nibble_burst_accumulator #(.BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_z(add_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .ovf(ovf)
  );

  nibble_burst_accumulator #(.BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .add_a(add_a1), .add_b(add_b1), .add_z(add_z1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1), .ovf(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {3'b000, obs}, {3'b000, exp});
  endtask

  function automatic logic exp_ovf();
    return OVF_EN && (model_tot > 15);
  endfunction

  // Offer one sample, wait (bounded) for in_ready, let it be accepted, then check the running state.
  task automatic feed(input logic [3:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check_bit("feed_ready_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    model_tot += d;
    model_n++;
    check("feed_sum", out_sum, 4'(model_tot));
    check_bit("feed_out_valid", out_valid, (model_n % BL) == 0);
  endtask

  task automatic expect_result(input string tag);
    check_bit({tag, "_valid"}, out_valid, 1'b1);
    check_bit({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_sum"}, out_sum, 4'(model_tot));
    check_bit({tag, "_ovf"}, ovf, exp_ovf());
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_tot = 0;
    check_bit("drain_valid", out_valid, 1'b0);
    check_bit("drain_in_ready", in_ready, 1'b1);
    check("drain_sum", out_sum, 4'h0);
    check_bit("drain_ovf", ovf, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = 4'h0; out_ready1 = 1'b0;
    tick();
    tick();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check("rst_sum", out_sum, 4'h0);
    check_bit("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    // 1: 1,2,3,4 back-to-back with out_ready held high.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'h1; tick(); model_tot += 1; model_n++;
    in_data = 4'h2; tick(); model_tot += 2; model_n++;
    in_data = 4'h3; tick(); model_tot += 3; model_n++;
    check_bit("t1_not_yet", out_valid, 1'b0);
    in_data = 4'h4; tick(); model_tot += 4; model_n++;
    in_valid = 1'b0;
    expect_result("t1");
    check("t1_literal", out_sum, 4'hA);
    drain();

    // 2: wrap through the adder.
    feed(4'h8); feed(4'h9); feed(4'h0); feed(4'h0);
    expect_result("t2");
    check("t2_literal", out_sum, 4'h1);
    check_bit("t2_ovf_literal", ovf, OVF_EN);
    drain();

    // 3: downstream stall while upstream keeps offering data.
    feed(4'h3); feed(4'h7); feed(4'h2); feed(4'hB);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      tick();
      check_bit("t3_hold_valid", out_valid, 1'b1);
      check_bit("t3_hold_in_ready", in_ready, 1'b0);
      check("t3_hold_sum", out_sum, 4'h7);
    end
    in_valid = 1'b0;
    expect_result("t3");
    drain();
    feed(4'h1); feed(4'h1); feed(4'h1); feed(4'h1);
    check("t3_restart", out_sum, 4'h4);
    drain();

    // 4: gapped valid; the F samples must never be taken.
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = (i % 2 == 0) ? 4'h2 : 4'hF;
      tick();
      if (i % 2 == 0) begin
        model_tot += 2;
        model_n++;
      end
      check("t4_running", out_sum, 4'(model_tot));
    end
    in_valid = 1'b0;
    expect_result("t4");
    check("t4_literal", out_sum, 4'h8);
    drain();

    // 5: reset mid-burst discards the partial sum.
    feed(4'h5); feed(4'h5);
    rst = 1'b1;
    tick();
    check_bit("t5_rst_valid", out_valid, 1'b0);
    check_bit("t5_rst_in_ready", in_ready, 1'b1);
    check("t5_rst_sum", out_sum, 4'h0);
    rst = 1'b0;
    model_tot = 0;
    model_n   = 0;
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    expect_result("t5");
    check("t5_literal", out_sum, 4'hA);
    drain();

    // Random bursts with random input gaps and downstream stalls.
    for (int b = 0; b < 20; b++) begin
      int stall;
      for (int s = 0; s < BL; s++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data  = 4'($urandom);
          tick();
          check("rnd_gap_sum", out_sum, 4'(model_tot));
        end
        feed(4'($urandom));
      end
      expect_result("rnd");
      stall = $urandom_range(0, 3);
      for (int c = 0; c < stall; c++) begin
        in_valid = 1'($urandom);
        in_data  = 4'($urandom);
        tick();
        expect_result("rnd_stall");
      end
      in_valid = 1'b0;
      drain();
    end

    // 6: BURST_LEN=1 instance, every sample is its own result.
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_data1 = 4'h7;
    tick();
    in_valid1 = 1'b0;
    check_bit("t6a_valid", out_valid1, 1'b1);
    check("t6a_sum", out_sum1, 4'h7);
    check_bit("t6a_ovf", ovf1, 1'b0);
    check_bit("t6a_in_ready", in_ready1, 1'b0);
    tick();
    check_bit("t6_drained", out_valid1, 1'b0);
    check_bit("t6_ready_again", in_ready1, 1'b1);
    in_valid1 = 1'b1; in_data1 = 4'hE;
    tick();
    in_valid1 = 1'b0;
    check_bit("t6b_valid", out_valid1, 1'b1);
    check("t6b_sum", out_sum1, 4'hE);
    check_bit("t6b_ovf", ovf1, 1'b0);
    tick();
    out_ready1 = 1'b0;
    check_bit("t6b_drained", out_valid1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
